// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths
// used by both the APB master and slave blocks.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_WIDTH      = 8;

endpackage

// File: rtl/apb_master_timer.sv
// ACCESS-phase watchdog for apb_master; only instantiated when
// APB_MASTER_TIMEOUT_EN is defined.
module apb_master_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // expired is high during the final permitted ACCESS cycle
  assign expired = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: request/response handshake in, APB bus out.
// Optional ACCESS timeout compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int WIDTH          = APB_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [3:0]            req_strb,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_slverr,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [WIDTH-1:0]      pwdata,
  output logic [3:0]            pstrb,
  input  logic [WIDTH-1:0]      prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  state_t state;
  logic   timeout_hit;

  assign req_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  logic timer_expired;

  apb_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == SETUP),
    .en     (state == ACCESS),
    .expired(timer_expired)
  );

  assign timeout_hit = timer_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      pstrb      <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr  <= req_addr;
            pwrite <= req_write;
            pwdata <= req_wdata;
            pstrb  <= req_write ? req_strb : 4'b0000;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready in the last counted cycle takes priority over the timeout
          if (pready) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_slverr <= pslverr;
            rsp_rdata  <= pwrite ? '0 : prdata;
            state      <= IDLE;
          end else if (timeout_hit) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_slverr <= 1'b1;
            rsp_rdata  <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the paddr/req_addr width.
REQ-002 Parameter WIDTH, default 8, SHALL set the data width (pwdata, prdata, req_wdata, rsp_rdata).
REQ-003 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum ACCESS cycles before abort (used only under REQ-025).
REQ-004 Reset rst_n SHALL be asynchronous, active-low; clock clk; all state SHALL update on posedge clk.
REQ-005 Clock and reset ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-006 Request ports: req_valid in 1 command valid; req_ready out 1 command accepted; req_addr in ADDR_WIDTH address; req_write in 1 (1=write, 0=read); req_wdata in WIDTH write data; req_strb in 4 byte strobes.
REQ-007 Response ports: rsp_valid out 1 one-cycle completion pulse; rsp_rdata out WIDTH read data; rsp_slverr out 1 error flag.
REQ-008 APB drive ports: paddr out ADDR_WIDTH; pwrite out 1; psel out 1; penable out 1; pwdata out WIDTH; pstrb out 4.
REQ-009 APB return ports: prdata in WIDTH; pready in 1; pslverr in 1.

Function
REQ-010 FSM states SHALL be IDLE, SETUP, ACCESS; all APB and response outputs SHALL be registered.
REQ-011 req_ready SHALL be 1 only in IDLE; a handshake (req_valid && req_ready) SHALL latch addr/write/wdata/strb and move to SETUP.
REQ-012 SETUP SHALL last exactly one cycle with psel=1, penable=0, then move to ACCESS.
REQ-013 ACCESS SHALL drive psel=1, penable=1 and stay until pready=1 is sampled.
REQ-014 paddr, pwrite, pwdata, pstrb SHALL hold the latched values for the whole SETUP+ACCESS span and SHALL not change while psel=1.
REQ-015 In IDLE: psel=0, penable=0; paddr/pwrite/pwdata/pstrb SHALL hold their last values.
REQ-016 On pready=1 in ACCESS: the next cycle SHALL have rsp_valid=1 for exactly one cycle, rsp_slverr=sampled pslverr, rsp_rdata=sampled prdata on reads and 0 on writes; the FSM SHALL return to IDLE.
REQ-017 With zero wait states, the minimum latency from handshake to rsp_valid SHALL be 3 cycles; transfers SHALL be spaced by at least one IDLE cycle (3-cycle throughput minimum).
REQ-018 prdata and pslverr SHALL be ignored in every cycle other than an ACCESS cycle with pready=1.
REQ-019 req_valid arriving outside IDLE SHALL not be accepted and SHALL be held by the requester.
REQ-020 rsp_rdata and rsp_slverr SHALL hold their values until the next rsp_valid.
REQ-021 pwrite SHALL equal the latched req_write; pstrb SHALL be driven to 0 on reads.

Reset
REQ-022 Assertion of rst_n SHALL immediately force state=IDLE, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pstrb=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0; req_ready SHALL be 1 from the first clock after deassertion.
REQ-023 Reset during SETUP or ACCESS SHALL abandon the transfer and SHALL produce no rsp_valid.

Configuration
REQ-024 Macro APB_MASTER_TIMEOUT_EN SHALL compile the ACCESS timeout in or out.
REQ-025 With the macro defined: a counter SHALL clear on entry to ACCESS; if TIMEOUT_CYCLES ACCESS cycles elapse with pready=0, the FSM SHALL return to IDLE with rsp_valid=1, rsp_slverr=1, rsp_rdata=0. pready=1 in the final counted cycle SHALL win over the timeout.
REQ-026 Without the macro: ACCESS SHALL wait indefinitely, and no counter logic SHALL exist.

Structure
REQ-027 Package apb_pkg SHALL hold the state_t enum (IDLE, SETUP, ACCESS) and the default ADDR_WIDTH/WIDTH localparams shared with apb_slave.
REQ-028 Sub-module apb_master_timer (timeout counter) SHALL be instantiated only under APB_MASTER_TIMEOUT_EN; all other logic SHALL be flat.

Verification
REQ-029 Write 0x5A to addr 0x03 with a zero-wait slave -> psel rises 1 cycle after the handshake, penable follows 1 cycle later, rsp_valid is seen 3 cycles after the handshake, rsp_slverr=0.
REQ-030 Read addr 0x03 after REQ-029 -> rsp_rdata=0x5A; pstrb=0 throughout the transfer.
REQ-031 Slave inserts 4 wait states -> penable=1 for 5 cycles, paddr/pwdata stable throughout, exactly one rsp_valid.
REQ-032 Slave returns pslverr=1 with pready=1 on write addr 0x10 -> rsp_slverr=1; the next transfer completes with rsp_slverr=0.
REQ-033 rst_n pulsed low in ACCESS -> psel/penable=0 immediately, no rsp_valid, a fresh write succeeds after reset.
REQ-034 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held at 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_slverr=1, rsp_rdata=0, state IDLE.
